// File: rtl/pipe_ctrl_hazard_if.sv
// Control bundle from the ID-stage decoder and the stage-qualified controls
// returned to the EX/MEM/WB datapath and the PC / IF/ID enables.
interface pipe_ctrl_hazard_if;
  logic [1:0] id_alu_op;
  logic       id_alu_src;
  logic       id_mem_2_reg;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_mem_write;
  logic       id_branch;
  logic       id_jump;
  logic       id_is_mult;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       ex_zero;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src;
  logic       ex_branch;
  logic       ex_jump;
  logic       ex_is_mult;
  logic [4:0] ex_rd;
  logic       mem_mem_read;
  logic       mem_mem_write;
  logic       mem_reg_write;
  logic       mem_mem_2_reg;
  logic [4:0] mem_rd;
  logic       wb_reg_write;
  logic       wb_mem_2_reg;
  logic [4:0] wb_rd;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       mult_busy;

  modport master (
    output id_alu_op, id_alu_src, id_mem_2_reg, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_is_mult, id_rs1, id_rs2, id_rd,
           ex_zero,
    input  ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_is_mult, ex_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_2_reg, mem_rd,
           wb_reg_write, wb_mem_2_reg, wb_rd,
           pc_write, if_id_write, if_id_flush, mult_busy
  );

  modport slave (
    input  id_alu_op, id_alu_src, id_mem_2_reg, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_is_mult, id_rs1, id_rs2, id_rd,
           ex_zero,
    output ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_is_mult, ex_rd,
           mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_2_reg, mem_rd,
           wb_reg_write, wb_mem_2_reg, wb_rd,
           pc_write, if_id_write, if_id_flush, mult_busy
  );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Control pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall, multi-cycle
// multiply hold and taken-branch/jump squash.
module pipe_ctrl_hazard #(
  parameter int MULT_CYCLES = 3
) (
  input logic               clk,
  input logic               arst,
  pipe_ctrl_hazard_if.slave bus
);
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_2_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       is_mult;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_2_reg;
    logic [4:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_2_reg;
    logic [4:0] rd;
  } mem_wb_t;

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_MULT     = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_LOAD_USE = 2'd3
  } action_e;

  localparam id_ex_t     ID_EX_BUBBLE  = 15'd0;
  localparam ex_mem_t    EX_MEM_BUBBLE = 9'd0;
  localparam mem_wb_t    MEM_WB_BUBBLE = 7'd0;
  localparam logic [1:0] MCNT_LOAD     = 2'(MULT_CYCLES - 1);

  id_ex_t     id_ex_r, id_bundle_s, id_ex_next_s;
  ex_mem_t    ex_mem_r, ex_adv_s, ex_mem_next_s;
  mem_wb_t    mem_wb_r, mem_adv_s;
  logic [1:0] mcnt_r, mcnt_next_s;
  action_e    action_s;
  logic       redirect_s, load_use_s, mult_busy_s;
  logic       pc_write_s, if_id_write_s, if_id_flush_s;

  // Gather the decoder bundle and the forward-moving slices of each stage.
  always_comb begin
    id_bundle_s = '{alu_op: bus.id_alu_op, alu_src: bus.id_alu_src,
                    mem_2_reg: bus.id_mem_2_reg, reg_write: bus.id_reg_write,
                    mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                    branch: bus.id_branch, jump: bus.id_jump,
                    is_mult: bus.id_is_mult, rd: bus.id_rd};
    ex_adv_s    = '{mem_read: id_ex_r.mem_read, mem_write: id_ex_r.mem_write,
                    reg_write: id_ex_r.reg_write, mem_2_reg: id_ex_r.mem_2_reg,
                    rd: id_ex_r.rd};
    mem_adv_s   = '{reg_write: ex_mem_r.reg_write, mem_2_reg: ex_mem_r.mem_2_reg,
                    rd: ex_mem_r.rd};
  end

  assign redirect_s  = (id_ex_r.branch & bus.ex_zero) | id_ex_r.jump;
  assign load_use_s  = id_ex_r.mem_read & (id_ex_r.rd != 5'd0) &
                       ((id_ex_r.rd == bus.id_rs1) | (id_ex_r.rd == bus.id_rs2));
  assign mult_busy_s = (mcnt_r != 2'd0);

  // Pick the single highest-priority pipeline action for this cycle.
  always_comb begin
    action_s = ACT_RUN;
    if (mult_busy_s) begin
      action_s = ACT_MULT;
    end else if (redirect_s) begin
      action_s = ACT_REDIRECT;
    end else if (load_use_s) begin
      action_s = ACT_LOAD_USE;
    end else begin
      action_s = ACT_RUN;
    end
  end

  // Next-state of the stage registers and the front-end enables.
  always_comb begin
    id_ex_next_s  = ID_EX_BUBBLE;
    ex_mem_next_s = ex_adv_s;
    mcnt_next_s   = 2'd0;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    if_id_flush_s = 1'b0;
    case (action_s)
      ACT_MULT: begin
        // The final multiply cycle (mcnt back to 0) runs as ACT_RUN.
        id_ex_next_s  = id_ex_r;
        ex_mem_next_s = EX_MEM_BUBBLE;
        mcnt_next_s   = mcnt_r - 2'd1;
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
      end
      ACT_REDIRECT: begin
        if_id_flush_s = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
      end
      ACT_RUN: begin
        id_ex_next_s = id_bundle_s;
        mcnt_next_s  = bus.id_is_mult ? MCNT_LOAD : 2'd0;
      end
      default: begin
        id_ex_next_s  = ID_EX_BUBBLE;
        ex_mem_next_s = EX_MEM_BUBBLE;
      end
    endcase
  end

  // Stage registers and multiply counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      id_ex_r  <= ID_EX_BUBBLE;
      ex_mem_r <= EX_MEM_BUBBLE;
      mem_wb_r <= MEM_WB_BUBBLE;
      mcnt_r   <= 2'd0;
    end else begin
      id_ex_r  <= id_ex_next_s;
      ex_mem_r <= ex_mem_next_s;
      mem_wb_r <= mem_adv_s;
      mcnt_r   <= mcnt_next_s;
    end
  end

  assign bus.ex_alu_op     = id_ex_r.alu_op;
  assign bus.ex_alu_src    = id_ex_r.alu_src;
  assign bus.ex_branch     = id_ex_r.branch;
  assign bus.ex_jump       = id_ex_r.jump;
  assign bus.ex_is_mult    = id_ex_r.is_mult;
  assign bus.ex_rd         = id_ex_r.rd;
  assign bus.mem_mem_read  = ex_mem_r.mem_read;
  assign bus.mem_mem_write = ex_mem_r.mem_write;
  assign bus.mem_reg_write = ex_mem_r.reg_write;
  assign bus.mem_mem_2_reg = ex_mem_r.mem_2_reg;
  assign bus.mem_rd        = ex_mem_r.rd;
  assign bus.wb_reg_write  = mem_wb_r.reg_write;
  assign bus.wb_mem_2_reg  = mem_wb_r.mem_2_reg;
  assign bus.wb_rd         = mem_wb_r.rd;
  assign bus.pc_write      = pc_write_s;
  assign bus.if_id_write   = if_id_write_s;
  assign bus.if_id_flush   = if_id_flush_s;
  assign bus.mult_busy     = mult_busy_s;
endmodule
